// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Purpose:
//   This is a keypad-entered M:SS countdown timer. Digits are shifted in from
//   the right while the timer is IDLE. start runs the count, stop pauses it,
//   and a second stop cancels it. The count goes down by one second on each
//   1 s tick. done pulses for one cycle when the count reaches 0:00.
//
// Configuration macro:
//   TIMER_PRESCALER_EN - when this macro is defined, the tick port is ignored.
//                        An internal counter then makes a one-cycle tick every
//                        TICK_DIV clocks. The counter runs only in RUN, clears
//                        on every entry to RUN, and holds in PAUSE.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   tick       in   one-cycle 1 s count enable (default build only)
//   digit_load in   keypad digit strobe
//   digit      in   [3:0] BCD keypad value (values above 9 are ignored)
//   start      in   start/resume request
//   stop       in   pause/cancel request (wins over start)
//   sec_ones   out  [3:0] registered BCD seconds ones
//   sec_tens   out  [3:0] registered BCD seconds tens
//   mins       out  [3:0] registered BCD minutes
//   running    out  high while in RUN (registered)
//   done       out  one-cycle pulse together with the 0:00 outputs
//   state_dbg  out  [1:0] current FSM state (0 IDLE, 1 RUN, 2 PAUSE)
//
// Handshake: there is no valid/ready flow control. Each control input is a
// single-cycle level that is sampled on the rising clock edge.
// ---------------------------------------------------------------------------
module countdown_timer #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       digit_load,
   input  logic [3:0] digit,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] mins,
   output logic       running,
   output logic       done,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t state;
   logic   tick_en;
   logic   count_zero;
   logic   count_last;

   assign count_zero = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
   assign count_last = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
   assign state_dbg  = state;

`ifdef TIMER_PRESCALER_EN
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] pre_cnt;
   logic          unused_tick;

   assign unused_tick = tick;
   assign tick_en     = (state == RUN) && (pre_cnt == CW'(TICK_DIV - 1));
`else
   assign tick_en = tick;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         mins     <= 4'd0;
         running  <= 1'b0;
         done     <= 1'b0;
`ifdef TIMER_PRESCALER_EN
         pre_cnt  <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (stop) begin
                  sec_ones <= 4'd0;
                  sec_tens <= 4'd0;
                  mins     <= 4'd0;
               end else if (start && !count_zero) begin
                  state   <= RUN;
                  running <= 1'b1;
`ifdef TIMER_PRESCALER_EN
                  pre_cnt <= '0;
`endif
               end else if (digit_load && (digit <= 4'd9)) begin
                  // Shift the entry in from the right. The old minutes digit is dropped.
                  mins     <= sec_tens;
                  sec_tens <= sec_ones;
                  sec_ones <= digit;
               end
            end

            RUN: begin
               if (stop) begin
                  // When stop and tick arrive together, the count is held.
                  state   <= PAUSE;
                  running <= 1'b0;
               end else begin
`ifdef TIMER_PRESCALER_EN
                  pre_cnt <= tick_en ? '0 : pre_cnt + 1'b1;
`endif
                  if (tick_en) begin
                     if (sec_ones != 4'd0) begin
                        sec_ones <= sec_ones - 4'd1;
                     end else begin
                        sec_ones <= 4'd9;
                        // Entered tens values 6..9 count down as is. Only a
                        // borrow from the minutes digit reloads the tens to 5.
                        if (sec_tens != 4'd0) begin
                           sec_tens <= sec_tens - 4'd1;
                        end else begin
                           sec_tens <= 4'd5;
                           mins     <= mins - 4'd1;
                        end
                     end
                     if (count_last) begin
                        done    <= 1'b1;
                        state   <= IDLE;
                        running <= 1'b0;
                     end
                  end
               end
            end

            PAUSE: begin
               if (stop) begin
                  sec_ones <= 4'd0;
                  sec_tens <= 4'd0;
                  mins     <= 4'd0;
                  state    <= IDLE;
               end else if (start) begin
                  state   <= RUN;
                  running <= 1'b1;
`ifdef TIMER_PRESCALER_EN
                  pre_cnt <= '0;
`endif
               end
            end

            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule
